block_loader: RTL and testbench
===============================

BLOCK_LOADER -- requirements
Module: block_loader

Interface
REQ-001 The block SHALL have parameter RATE_WORDS, default 17, meaning words per rate block (17 for SHAKE256, 21 for SHAKE128).
REQ-002 The block SHALL have parameter LEN_WIDTH, default 32, meaning the width of the message byte-length field.
REQ-003 The block SHALL use w, w_byte_width and w_byte_size from keccak_pkg.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a new message.
REQ-007 The block SHALL have port msg_len, input, LEN_WIDTH bits: message length in bytes, sampled when start is accepted.
REQ-008 The block SHALL have port in_valid / in_ready, input / output, 1 bit each: message word handshake.
REQ-009 The block SHALL have port data_in, input, w bits: message word.
REQ-010 The block SHALL have port out_valid / out_ready, output / input, 1 bit each: word handshake to the padding stage.
REQ-011 The block SHALL have port data_out, output, w bits: word to the padding stage.
REQ-012 The block SHALL have port remaining_valid_bytes, output, w_byte_width bits: count of valid message bytes in the current word.
REQ-013 The block SHALL have ports padding_enable, last_word_in_block and padding_reset, each output, 1 bit: padding-stage controls.
REQ-014 The block SHALL have port block_full, output, 1 bit: one-cycle pulse when the last word of a block transfers.
REQ-015 The block SHALL have port permute_done, input, 1 bit: pulse meaning the permutation has finished the current block.
REQ-016 The block SHALL have ports busy and msg_done, each output, 1 bit: busy is high outside IDLE; msg_done is a one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, ABSORB, PAD and WAIT_PERM.
REQ-018 In IDLE, start SHALL be accepted at any cycle.
- Load byte counter rem_bytes with msg_len; clear word_idx and pad_started.
- Pulse padding_reset for exactly that one cycle.
- Next state: ABSORB if msg_len != 0, else PAD.
REQ-019 In ABSORB, words SHALL pass through combinationally with zero latency.
- in_ready = out_ready; out_valid = in_valid; data_out = data_in.
- A transfer occurs when out_valid && out_ready.
REQ-020 In ABSORB, while rem_bytes >= 8, padding_enable SHALL be 0; each transfer subtracts 8 from rem_bytes.
REQ-021 In ABSORB, when 0 < rem_bytes < 8, the word SHALL be flagged and padding SHALL start.
- padding_enable = 1; remaining_valid_bytes = rem_bytes[2:0].
- On transfer: set pad_started, set rem_bytes to 0.
REQ-022 In ABSORB, a transfer that makes rem_bytes exactly 0 SHALL move the FSM to PAD at the next word slot (the whole-word pad case).
REQ-023 In PAD, the block SHALL emit padding words without consuming input.
- in_ready = 0; out_valid = 1; data_out = 0.
- padding_enable = 1; remaining_valid_bytes = 0.
- Set pad_started on the first transfer.
REQ-024 last_word_in_block SHALL equal (word_idx == RATE_WORDS-1) whenever out_valid is high, in every state.
REQ-025 word_idx SHALL increment on each transfer and wrap to 0 after RATE_WORDS-1.
- The wrapping transfer pulses block_full and moves the FSM to WAIT_PERM.
REQ-026 In WAIT_PERM, out_valid and in_ready SHALL both be 0.
- On permute_done: if pad_started, go to IDLE and pulse msg_done.
- Otherwise go to ABSORB, or to PAD if rem_bytes == 0.
REQ-027 A partial word that lands on word RATE_WORDS-1 SHALL carry padding_enable=1 and last_word_in_block=1 together, then go to WAIT_PERM and finish.
REQ-028 start SHALL be ignored while busy; permute_done SHALL be ignored outside WAIT_PERM.
REQ-029 With out_ready low, all outputs SHALL hold stable and no counter SHALL change.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL enter IDLE and clear rem_bytes, word_idx and pad_started.
REQ-031 During and after reset, all outputs SHALL be 0: out_valid, in_ready, padding_enable, last_word_in_block, block_full, msg_done, busy, padding_reset, and data_out.
REQ-032 rst asserted mid-message SHALL abandon the message; no msg_done SHALL follow.

Configuration
REQ-033 With macro BLOCK_LOADER_ABORT_EN defined, the block SHALL add input port abort (1 bit).
- abort high in any non-IDLE state: next state IDLE, counters cleared, padding_reset pulsed, no msg_done.
- abort takes priority over every other event in that cycle.
REQ-034 Without BLOCK_LOADER_ABORT_EN, the abort port and its logic SHALL NOT exist.

Verification
REQ-035 Case msg_len=0, RATE_WORDS=17 -> 17 pad words; the first has remaining_valid_bytes=0 and padding_enable=1, word 16 has last_word_in_block=1; then block_full; after permute_done, msg_done.
REQ-036 Case msg_len=13 -> word0 has padding_enable=0; word1 has padding_enable=1 and remaining_valid_bytes=5; words 2..16 are pad words; exactly one block.
REQ-037 Case msg_len=136 -> 17 data words, WAIT_PERM, permute_done, then a second block of 17 pad words, then msg_done after the second permute_done.
REQ-038 Case msg_len=135 -> word 16 carries padding_enable=1, remaining_valid_bytes=7 and last_word_in_block=1; single block; msg_done.
REQ-039 Case random out_ready/in_valid stalls plus start while busy -> outputs hold during stalls; start ignored; word count and data order unchanged.
REQ-040 Case rst (and abort, if enabled) mid-ABSORB -> all outputs 0 next cycle; a new start succeeds with padding_reset pulsed.

Source files
------------

// File: rtl/block_loader.sv
// Rate-block loader: zero-latency word pass-through in ABSORB, then pad words. Back-pressure via out_ready stalls everything.
// Optional abort input is enabled by defining BLOCK_LOADER_ABORT_EN.
package keccak_pkg;
  localparam int w            = 64;
  localparam int w_byte_size  = 8;
  localparam int w_byte_width = 3;
endpackage

module block_loader
  import keccak_pkg::*;
#(
  parameter int RATE_WORDS = 17,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    msg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [w-1:0]            data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [w-1:0]            data_out,
  output logic [w_byte_width-1:0] remaining_valid_bytes,
  output logic                    padding_enable,
  output logic                    last_word_in_block,
  output logic                    padding_reset,
  output logic                    block_full,
  input  logic                    permute_done,
`ifdef BLOCK_LOADER_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    busy,
  output logic                    msg_done
);

  localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(RATE_WORDS - 1);
  localparam logic [LEN_WIDTH-1:0] WORD_LEN  = LEN_WIDTH'(w_byte_size);

  typedef enum logic [1:0] {IDLE, ABSORB, PAD, WAIT_PERM} state_t;

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    rem_bytes, rem_nxt;
  logic [IDX_W-1:0]        word_idx, idx_nxt;
  logic                    pad_started, pad_nxt;
  logic                    last_idx;
  logic                    abort_req;

  logic                    ov, ir, pe, bf, md, pr;
  logic [w-1:0]            dout;
  logic [w_byte_width-1:0] rvb;

`ifdef BLOCK_LOADER_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign last_idx = (word_idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_bytes;
    idx_nxt   = word_idx;
    pad_nxt   = pad_started;
    ov        = 1'b0;
    ir        = 1'b0;
    dout      = '0;
    pe        = 1'b0;
    rvb       = '0;
    bf        = 1'b0;
    md        = 1'b0;
    pr        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pr        = 1'b1;
          rem_nxt   = msg_len;
          idx_nxt   = '0;
          pad_nxt   = 1'b0;
          state_nxt = (msg_len != '0) ? ABSORB : PAD;
        end
      end

      ABSORB: begin
        ir   = out_ready;
        ov   = in_valid;
        dout = data_in;
        // A short tail word carries its byte count and starts the padding.
        if (rem_bytes < WORD_LEN) begin
          pe  = 1'b1;
          rvb = rem_bytes[w_byte_width-1:0];
        end
        if (in_valid && out_ready) begin
          if (rem_bytes < WORD_LEN) begin
            rem_nxt = '0;
            pad_nxt = 1'b1;
          end else begin
            rem_nxt = rem_bytes - WORD_LEN;
          end
          idx_nxt = last_idx ? '0 : word_idx + 1'b1;
          if (last_idx) begin
            bf        = 1'b1;
            state_nxt = WAIT_PERM;
          end else if (rem_nxt == '0) begin
            state_nxt = PAD;
          end
        end
      end

      PAD: begin
        ov = 1'b1;
        pe = 1'b1;
        if (out_ready) begin
          pad_nxt = 1'b1;
          idx_nxt = last_idx ? '0 : word_idx + 1'b1;
          if (last_idx) begin
            bf        = 1'b1;
            state_nxt = WAIT_PERM;
          end
        end
      end

      WAIT_PERM: begin
        if (permute_done) begin
          if (pad_started) begin
            md        = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = (rem_bytes == '0) ? PAD : ABSORB;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Abort wins over any transfer, block completion or message completion.
    if (abort_req) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
      idx_nxt   = '0;
      pad_nxt   = 1'b0;
      ov        = 1'b0;
      ir        = 1'b0;
      dout      = '0;
      pe        = 1'b0;
      rvb       = '0;
      bf        = 1'b0;
      md        = 1'b0;
      pr        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_bytes   <= '0;
      word_idx    <= '0;
      pad_started <= 1'b0;
    end else begin
      state       <= state_nxt;
      rem_bytes   <= rem_nxt;
      word_idx    <= idx_nxt;
      pad_started <= pad_nxt;
    end
  end

  // Outputs are forced low while reset is asserted, even before the first edge.
  assign out_valid             = !rst && ov;
  assign in_ready              = !rst && ir;
  assign data_out              = rst ? '0 : dout;
  assign padding_enable        = !rst && pe;
  assign remaining_valid_bytes = rst ? '0 : rvb;
  assign last_word_in_block    = !rst && ov && last_idx;
  assign block_full            = !rst && bf;
  assign msg_done              = !rst && md;
  assign padding_reset         = !rst && pr;
  assign busy                  = !rst && (state != IDLE);

endmodule

// File: tb/tb_block_loader.sv
// Directed vector bench for block_loader (RATE_WORDS=17, 64-bit words).
module tb_block_loader;
  import keccak_pkg::*;

  localparam int   RW = 17;
  localparam logic H  = 1'b1;
  localparam logic L  = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] msg_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] data_out;
  logic [2:0]  remaining_valid_bytes;
  logic        padding_enable, last_word_in_block, padding_reset;
  logic        block_full;
  logic        permute_done = 1'b0;
  logic        busy, msg_done;
`ifdef BLOCK_LOADER_ABORT_EN
  logic        abort = 1'b0;
`endif

  always #5 clk = ~clk;

  block_loader #(.RATE_WORDS(RW), .LEN_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .remaining_valid_bytes(remaining_valid_bytes),
    .padding_enable(padding_enable), .last_word_in_block(last_word_in_block),
    .padding_reset(padding_reset), .block_full(block_full),
    .permute_done(permute_done),
`ifdef BLOCK_LOADER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .msg_done(msg_done)
  );

  typedef struct {
    logic        rst, start;
    logic [31:0] len;
    logic        iv;
    logic [63:0] din;
    logic        ordy, pd;
    logic        ov, ir;
    logic [63:0] dout;
    logic        pe;
    logic [2:0]  rvb;
    logic        lw, bf, bsy, md, pr;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic r, input logic st, input logic [31:0] len,
                              input logic iv, input logic [63:0] din, input logic ordy,
                              input logic pd, input logic ov, input logic ir,
                              input logic [63:0] dout, input logic pe, input logic [2:0] rvb,
                              input logic lw, input logic bf, input logic bsy,
                              input logic md, input logic pr);
    vec_t v;
    v.rst = r; v.start = st; v.len = len; v.iv = iv; v.din = din; v.ordy = ordy; v.pd = pd;
    v.ov = ov; v.ir = ir; v.dout = dout; v.pe = pe; v.rvb = rvb;
    v.lw = lw; v.bf = bf; v.bsy = bsy; v.md = md; v.pr = pr;
    return v;
  endfunction

  task automatic chk(input string tag, input string f, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h, expected %0h", tag, f, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; start = v.start; msg_len = v.len; in_valid = v.iv;
    data_in = v.din; out_ready = v.ordy; permute_done = v.pd;
    #1;
    n_vec++;
    chk(tag, "out_valid", 64'(out_valid), 64'(v.ov));
    chk(tag, "in_ready", 64'(in_ready), 64'(v.ir));
    chk(tag, "data_out", data_out, v.dout);
    chk(tag, "padding_enable", 64'(padding_enable), 64'(v.pe));
    chk(tag, "remaining_valid_bytes", 64'(remaining_valid_bytes), 64'(v.rvb));
    chk(tag, "last_word_in_block", 64'(last_word_in_block), 64'(v.lw));
    chk(tag, "block_full", 64'(block_full), 64'(v.bf));
    chk(tag, "busy", 64'(busy), 64'(v.bsy));
    chk(tag, "msg_done", 64'(msg_done), 64'(v.md));
    chk(tag, "padding_reset", 64'(padding_reset), 64'(v.pr));
  endtask

  task automatic idle_quiet(input string tag);
    apply(mk(L, L, 32'd0, L, 64'd0, H, L, L, L, 64'd0, L, 3'd0, L, L, L, L, L), tag);
  endtask

  task automatic start_msg(input logic [31:0] len, input string tag);
    apply(mk(L, H, len, L, 64'd0, H, L, L, L, 64'd0, L, 3'd0, L, L, L, L, H), tag);
  endtask

  task automatic data_word(input int idx, input logic [63:0] d, input logic pe,
                           input logic [2:0] rvb, input logic pd, input string tag);
    logic last;
    last = (idx == RW - 1);
    apply(mk(L, L, 32'd0, H, d, H, pd, H, H, d, pe, rvb, last, last, H, L, L), tag);
  endtask

  task automatic pad_word(input int idx, input string tag);
    logic last;
    last = (idx == RW - 1);
    apply(mk(L, L, 32'd0, L, 64'd0, H, L, H, L, 64'd0, H, 3'd0, last, last, H, L, L), tag);
  endtask

  task automatic finish_block(input logic md_exp, input string tag);
    apply(mk(L, L, 32'd0, H, 64'hDEAD, H, L, L, L, 64'd0, L, 3'd0, L, L, H, L, L), {tag, "_wait"});
    apply(mk(L, L, 32'd0, L, 64'd0, H, H, L, L, 64'd0, L, 3'd0, L, L, H, md_exp, L), {tag, "_perm"});
  endtask

  vec_t tbl[10];

  initial begin
    // Reset with inputs active, idle behaviour, then msg_len=13 with stalls.
    tbl[0] = mk(H, H, 32'd13, H, 64'hFFFF, H, H, L, L, 64'd0,  L, 3'd0, L, L, L, L, L);
    tbl[1] = mk(L, L, 32'd0,  L, 64'd0,    H, L, L, L, 64'd0,  L, 3'd0, L, L, L, L, L);
    tbl[2] = mk(L, L, 32'd0,  L, 64'd0,    H, H, L, L, 64'd0,  L, 3'd0, L, L, L, L, L);
    tbl[3] = mk(L, H, 32'd13, L, 64'd0,    H, L, L, L, 64'd0,  L, 3'd0, L, L, L, L, H);
    tbl[4] = mk(L, L, 32'd0,  L, 64'hA0A0, H, L, L, H, 64'hA0A0, L, 3'd0, L, L, H, L, L);
    tbl[5] = mk(L, L, 32'd0,  H, 64'hA0A0, H, L, H, H, 64'hA0A0, L, 3'd0, L, L, H, L, L);
    tbl[6] = mk(L, H, 32'd99, H, 64'hB1B1, L, L, H, L, 64'hB1B1, H, 3'd5, L, L, H, L, L);
    tbl[7] = mk(L, H, 32'd99, H, 64'hB1B1, L, L, H, L, 64'hB1B1, H, 3'd5, L, L, H, L, L);
    tbl[8] = mk(L, L, 32'd0,  H, 64'hB1B1, H, L, H, H, 64'hB1B1, H, 3'd5, L, L, H, L, L);
    tbl[9] = mk(L, L, 32'd0,  L, 64'd0,    L, L, H, L, 64'd0,  H, 3'd0, L, L, H, L, L);

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("len13_v%0d", i));
    for (int i = 2; i < RW; i++) pad_word(i, $sformatf("len13_pad%0d", i));
    finish_block(H, "len13");
    idle_quiet("len13_idle");

    // Empty message: one block made entirely of pad words.
    start_msg(32'd0, "len0_start");
    for (int i = 0; i < RW; i++) pad_word(i, $sformatf("len0_pad%0d", i));
    finish_block(H, "len0");
    idle_quiet("len0_idle");

    // Exactly one full block of data, then a whole block of padding.
    start_msg(32'd136, "len136_start");
    for (int i = 0; i < RW; i++)
      data_word(i, 64'h1000 + 64'(i), L, 3'd0, (i == 3), $sformatf("len136_d%0d", i));
    finish_block(L, "len136_b0");
    for (int i = 0; i < RW; i++) pad_word(i, $sformatf("len136_pad%0d", i));
    finish_block(H, "len136_b1");
    idle_quiet("len136_idle");

    // Tail of 7 bytes lands on the last word of the block.
    start_msg(32'd135, "len135_start");
    for (int i = 0; i < RW - 1; i++)
      data_word(i, 64'h2000 + 64'(i), L, 3'd0, L, $sformatf("len135_d%0d", i));
    data_word(RW - 1, 64'h2FFF, H, 3'd7, L, "len135_tail");
    finish_block(H, "len135");
    idle_quiet("len135_idle");

    // Reset mid-absorb abandons the message; a fresh 8-byte message follows.
    start_msg(32'd40, "rst_start");
    data_word(0, 64'h3000, L, 3'd0, L, "rst_d0");
    data_word(1, 64'h3001, L, 3'd0, L, "rst_d1");
    apply(mk(H, L, 32'd0, H, 64'h3002, H, L, L, L, 64'd0, L, 3'd0, L, L, L, L, L), "rst_mid");
    idle_quiet("rst_after");
    start_msg(32'd8, "len8_start");
    data_word(0, 64'h4000, L, 3'd0, L, "len8_d0");
    for (int i = 1; i < RW; i++) pad_word(i, $sformatf("len8_pad%0d", i));
    finish_block(H, "len8");
    idle_quiet("len8_idle");

`ifdef BLOCK_LOADER_ABORT_EN
    start_msg(32'd40, "abort_start");
    data_word(0, 64'h5000, L, 3'd0, L, "abort_d0");
    abort = 1'b1;
    apply(mk(L, L, 32'd0, H, 64'h5001, H, L, L, L, 64'd0, L, 3'd0, L, L, H, L, H), "abort_mid");
    abort = 1'b0;
    idle_quiet("abort_after");
    start_msg(32'd0, "abort_restart");
    pad_word(0, "abort_pad0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
